// File: rtl/param_alu_pipe_if.sv
// Operand/result bus for param_alu_pipe: valid/ready input side, one-deep registered output side.
interface param_alu_pipe_if #(
   parameter int WIDTH = 16
);
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [4:0]       fun_sel;
   logic             wf;
   logic             in_valid;
   logic             in_ready;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] alu_out;
   logic [3:0]       flags_out;

   modport master (
      output a, b, fun_sel, wf, in_valid, out_ready,
      input  in_ready, out_valid, alu_out, flags_out
   );

   modport slave (
      input  a, b, fun_sel, wf, in_valid, out_ready,
      output in_ready, out_valid, alu_out, flags_out
   );
endinterface

// File: rtl/param_alu_pipe.sv
// Registered 16-op ALU with full/half operand width and persistent {Z,C,N,O} flags.
// Optional feature: define ALU_SAT_EN to saturate ADD/ADC/SUB on signed overflow.
module param_alu_pipe #(
   parameter int WIDTH = 16
) (
   input logic           clk,
   input logic           rst,
   param_alu_pipe_if.slave bus
);
   localparam int HALF  = WIDTH / 2;
   localparam int MSB_W = $clog2(WIDTH);

   logic [WIDTH-1:0] result_p1;
   logic [3:0]       flags_p1;
   logic             vld_p1;

   logic             half;
   logic [3:0]       op;
   logic [MSB_W-1:0] msb;
   logic [WIDTH-1:0] mask;
   logic [WIDTH-1:0] top_bit;
   logic [WIDTH-1:0] a_w;
   logic [WIDTH-1:0] b_w;
   logic [WIDTH-1:0] add_b;
   logic             add_cin;
   logic [WIDTH:0]   sum;
   logic             carry;
   logic             sa;
   logic             sb;
   logic             ovf;
   logic             cin;
   logic [WIDTH-1:0] res;
   logic             c_new;
   logic             o_new;
   logic [3:0]       new_flags;
   logic             accept;

   function automatic logic [WIDTH-1:0] saturate(
      input logic [WIDTH-1:0] r,
      input logic             overflow,
      input logic             neg,
      input logic [WIDTH-1:0] m,
      input logic [WIDTH-1:0] top
   );
      if (!overflow)
         return r;
      return neg ? top : (m >> 1);
   endfunction

   assign half    = ~bus.fun_sel[4];
   assign op      = bus.fun_sel[3:0];
   assign msb     = half ? MSB_W'(HALF - 1) : MSB_W'(WIDTH - 1);
   assign mask    = half ? {{(WIDTH - HALF){1'b0}}, {HALF{1'b1}}} : {WIDTH{1'b1}};
   assign top_bit = WIDTH'(1) << msb;
   assign a_w     = bus.a & mask;
   assign b_w     = bus.b & mask;
   assign cin     = flags_p1[2];

   // Shared adder: subtract is A + ~B + 1 within the active width.
   always_comb begin
      add_b   = b_w;
      add_cin = 1'b0;
      if (op == 4'h6) begin
         add_b   = ~b_w & mask;
         add_cin = 1'b1;
      end else if (op == 4'h5) begin
         add_cin = cin;
      end
   end

   assign sum   = {1'b0, a_w} + {1'b0, add_b} + (WIDTH + 1)'(add_cin);
   assign carry = half ? sum[HALF] : sum[WIDTH];
   assign sa    = a_w[msb];
   assign sb    = b_w[msb];
   assign ovf   = (op == 4'h6) ? ((sa != sb) && (sum[msb] != sa))
                               : ((sa == sb) && (sum[msb] != sa));

   always_comb begin
      res   = '0;
      c_new = cin;
      o_new = flags_p1[0];
      case (op)
         4'h0: res = a_w;
         4'h1: res = b_w;
         4'h2: res = ~a_w & mask;
         4'h3: res = ~b_w & mask;
         4'h4, 4'h5, 4'h6: begin
            res   = sum[WIDTH-1:0] & mask;
`ifdef ALU_SAT_EN
            res   = saturate(res, ovf, sa, mask, top_bit);
`endif
            c_new = carry;
            o_new = ovf;
         end
         4'h7: res = a_w & b_w;
         4'h8: res = a_w | b_w;
         4'h9: res = a_w ^ b_w;
         4'hA: res = ~(a_w & b_w) & mask;
         4'hB: begin
            res   = (a_w << 1) & mask;
            c_new = a_w[msb];
         end
         4'hC: begin
            res   = a_w >> 1;
            c_new = a_w[0];
         end
         4'hD: begin
            res   = (a_w >> 1) | (sa ? top_bit : '0);
            c_new = a_w[0];
         end
         4'hE: begin
            res   = ((a_w << 1) | WIDTH'(cin)) & mask;
            c_new = a_w[msb];
         end
         4'hF: begin
            res   = (a_w >> 1) | (cin ? top_bit : '0);
            c_new = a_w[0];
         end
      endcase
   end

   assign new_flags = {(res == '0), c_new, res[msb], o_new};

   assign bus.in_ready = ~vld_p1 | bus.out_ready;
   assign accept       = bus.in_valid & bus.in_ready;

   // Output stage: one-deep result register, flags persist across operations.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1    <= 1'b0;
         result_p1 <= '0;
         flags_p1  <= '0;
      end else if (accept) begin
         vld_p1    <= 1'b1;
         result_p1 <= res;
         if (bus.wf)
            flags_p1 <= new_flags;
      end else if (bus.out_ready) begin
         vld_p1 <= 1'b0;
      end
   end

   assign bus.out_valid = vld_p1;
   assign bus.alu_out   = result_p1;
   assign bus.flags_out = flags_p1;
endmodule

// File: tb/tb_param_alu_pipe.sv
// Directed table-driven bench for param_alu_pipe (WIDTH=16), honours ALU_SAT_EN.
module tb_param_alu_pipe;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   param_alu_pipe_if #(.WIDTH(16)) bus ();
   param_alu_pipe #(.WIDTH(16)) dut (.clk(clk), .rst(rst), .bus(bus));

`ifdef ALU_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   typedef struct {
      logic [4:0]  fs;
      logic [15:0] a;
      logic [15:0] b;
      logic        wf;
      logic [15:0] exp_out;
      logic [3:0]  exp_flags;
      string       name;
   } vec_t;

   localparam int NV = 24;
   vec_t vecs[NV];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [4:0] fs, input logic [15:0] a, input logic [15:0] b,
                        input logic wf, input logic vld, input logic ordy);
      bus.fun_sel   = fs;
      bus.a         = a;
      bus.b         = b;
      bus.wf        = wf;
      bus.in_valid  = vld;
      bus.out_ready = ordy;
   endtask

   initial begin
      vecs[0]  = '{5'h14, 16'hFFFF, 16'h0001, 1'b1, 16'h0000, 4'b1100, "add_carry"};
      vecs[1]  = '{5'h15, 16'h0000, 16'h0000, 1'b1, 16'h0001, 4'b0000, "adc_cin"};
      vecs[2]  = '{5'h04, 16'h1270, 16'h3410, 1'b1, SAT ? 16'h007F : 16'h0080,
                   SAT ? 4'b0001 : 4'b0011, "half_add_ovf"};
      vecs[3]  = '{5'h14, 16'h0001, 16'h0001, 1'b1, 16'h0002, 4'b0000, "add_small"};
      vecs[4]  = '{5'h16, 16'h0003, 16'h0005, 1'b0, 16'hFFFE, 4'b0000, "sub_nowf"};
      vecs[5]  = '{5'h14, 16'hFFFF, 16'h0001, 1'b1, 16'h0000, 4'b1100, "add_setc"};
      vecs[6]  = '{5'h1E, 16'h8001, 16'h0000, 1'b1, 16'h0003, 4'b0100, "rol"};
      vecs[7]  = '{5'h1F, 16'h0003, 16'h0000, 1'b1, 16'h8001, 4'b0110, "ror"};
      vecs[8]  = '{5'h17, 16'hF0F0, 16'hFF00, 1'b1, 16'hF000, 4'b0110, "and"};
      vecs[9]  = '{5'h08, 16'h12F0, 16'h340F, 1'b1, 16'h00FF, 4'b0110, "half_or"};
      vecs[10] = '{5'h19, 16'hAAAA, 16'hAAAA, 1'b1, 16'h0000, 4'b1100, "xor"};
      vecs[11] = '{5'h1A, 16'hFFFF, 16'hFFFF, 1'b1, 16'h0000, 4'b1100, "nand"};
      vecs[12] = '{5'h02, 16'hABFF, 16'h0000, 1'b1, 16'h0000, 4'b1100, "half_nota"};
      vecs[13] = '{5'h13, 16'h0000, 16'h0F0F, 1'b1, 16'hF0F0, 4'b0110, "notb"};
      vecs[14] = '{5'h11, 16'h1234, 16'h0000, 1'b1, 16'h0000, 4'b1100, "passb"};
      vecs[15] = '{5'h0B, 16'h5581, 16'h0000, 1'b1, 16'h0002, 4'b0100, "half_lsl"};
      vecs[16] = '{5'h1C, 16'h0001, 16'h0000, 1'b1, 16'h0000, 4'b1100, "lsr"};
      vecs[17] = '{5'h1D, 16'h8002, 16'h0000, 1'b1, 16'hC001, 4'b0010, "asr"};
      vecs[18] = '{5'h0D, 16'hFF84, 16'h0000, 1'b1, 16'h00C2, 4'b0010, "half_asr"};
      vecs[19] = '{5'h16, 16'h8000, 16'h0001, 1'b1, SAT ? 16'h8000 : 16'h7FFF,
                   SAT ? 4'b0111 : 4'b0101, "sub_ovf"};
      vecs[20] = '{5'h14, 16'h7FFF, 16'h0001, 1'b1, SAT ? 16'h7FFF : 16'h8000,
                   SAT ? 4'b0001 : 4'b0011, "add_ovf"};
      vecs[21] = '{5'h06, 16'h9910, 16'h2210, 1'b1, 16'h0000, 4'b1100, "half_sub_zero"};
      vecs[22] = '{5'h05, 16'h00FF, 16'h0000, 1'b1, 16'h0000, 4'b1100, "half_adc_carry"};
      vecs[23] = '{5'h0E, 16'h0040, 16'h0000, 1'b1, 16'h0081, 4'b0010, "half_rol"};

      // Reset held two cycles while an operation is offered.
      rst = 1'b1;
      drive(5'h14, 16'hFFFF, 16'h0001, 1'b1, 1'b1, 1'b1);
      tick;
      tick;
      chk("rst_out_valid", 16'(bus.out_valid), 16'h0000);
      chk("rst_alu_out", bus.alu_out, 16'h0000);
      chk("rst_flags", 16'(bus.flags_out), 16'h0000);
      chk("rst_in_ready", 16'(bus.in_ready), 16'h0001);
      rst = 1'b0;

      for (int i = 0; i < NV; i++) begin
         drive(vecs[i].fs, vecs[i].a, vecs[i].b, vecs[i].wf, 1'b1, 1'b1);
         tick;
         chk({vecs[i].name, "_valid"}, 16'(bus.out_valid), 16'h0001);
         chk({vecs[i].name, "_out"}, bus.alu_out, vecs[i].exp_out);
         chk({vecs[i].name, "_flags"}, 16'(bus.flags_out), 16'(vecs[i].exp_flags));
      end

      // Backpressure: result must hold and new ops must be refused.
      drive(5'h10, 16'h1234, 16'h0000, 1'b0, 1'b1, 1'b1);
      tick;
      chk("bp_first_out", bus.alu_out, 16'h1234);
      drive(5'h10, 16'h5555, 16'h0000, 1'b0, 1'b1, 1'b0);
      #1;
      chk("bp_in_ready_low", 16'(bus.in_ready), 16'h0000);
      for (int k = 0; k < 3; k++) begin
         tick;
         chk("bp_hold_ready", 16'(bus.in_ready), 16'h0000);
         chk("bp_hold_valid", 16'(bus.out_valid), 16'h0001);
         chk("bp_hold_out", bus.alu_out, 16'h1234);
         chk("bp_hold_flags", 16'(bus.flags_out), 16'(vecs[NV-1].exp_flags));
      end
      bus.out_ready = 1'b1;
      #1;
      chk("bp_release_ready", 16'(bus.in_ready), 16'h0001);
      tick;
      chk("bp_release_out", bus.alu_out, 16'h5555);
      chk("bp_release_valid", 16'(bus.out_valid), 16'h0001);

      // Drain: valid drops, data holds.
      bus.in_valid = 1'b0;
      tick;
      chk("drain_valid", 16'(bus.out_valid), 16'h0000);
      chk("drain_out", bus.alu_out, 16'h5555);

      // Reset beats a simultaneous accept.
      drive(5'h10, 16'h7777, 16'h0000, 1'b1, 1'b1, 1'b1);
      rst = 1'b1;
      tick;
      chk("rst_win_valid", 16'(bus.out_valid), 16'h0000);
      chk("rst_win_out", bus.alu_out, 16'h0000);
      chk("rst_win_flags", 16'(bus.flags_out), 16'h0000);
      rst = 1'b0;
      bus.in_valid = 1'b0;
      tick;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
